dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller between the core's load/store stage and the single-port, read-first, word-wide data RAM. It accepts one byte, halfword or word access at a time and maps it onto the RAM's word address/data/write-enable port. Sub-word stores are performed as read-modify-write because the RAM has no byte enables. Loads are lane-extracted and sign- or zero-extended, and misaligned or out-of-range accesses return an error response without touching memory.

## Interface
Parameters:
- RAM_DEPTH, 1024: RAM depth in 32-bit words; ADDR_W = $clog2(RAM_DEPTH).
- RAM_LATENCY, 1: RAM read latency in cycles. 1 matches LOW_LATENCY and 2 matches HIGH_PERFORMANCE; no other values are legal.
- BASE_ADDR, 32'h0000_0000: byte address of RAM word 0; must be word-aligned.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  access request
- req_ready  out  1  request accepted when valid && ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend a load when set
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  misaligned, out-of-range or illegal size; qualified by resp_valid
- resp_rdata  out  32  load result; 0 for stores and errors
- ram_addr  out  ADDR_W  RAM word address
- ram_din  out  32  RAM write data
- ram_we  out  1  RAM write enable
- ram_regce  out  1  RAM output-register enable
- ram_dout  in  32  RAM read data

## Operation
- FSM states are IDLE, ACCESS, WAIT, MERGE and RESP.
- **IDLE**
  - req_ready=1; every other output is 0.
  - On accept, the request is latched and the error check is evaluated.
  - An error (offset = addr-BASE_ADDR ≥ 4·RAM_DEPTH, half with addr[0]=1, word with addr[1:0]≠0, or size 11) goes to RESP with err=1.
  - Any other request goes to ACCESS.
- **ACCESS** (1 cycle)
  - ram_addr = offset[ADDR_W+1:2] and ram_regce=1.
  - A word store drives ram_we=1 and ram_din=wdata, then goes to RESP.
  - Every other access (load or sub-word store) goes to WAIT.
- **WAIT** (RAM_LATENCY cycles, counted)
  - ram_addr is held and ram_regce=1.
  - In the final cycle, ram_dout is captured.
  - A load registers its extracted result and goes to RESP.
  - A sub-word store registers its merged word and goes to MERGE.
- **MERGE** (1 cycle): ram_we=1, ram_addr held, ram_din = merged word; then goes to RESP.
- **RESP** (1 cycle): resp_valid=1 with the registered err/rdata; then goes to IDLE.
- Byte lane = addr[1:0]; halfword lane = addr[1].
- Load extraction: sign-extend from bit 7 or bit 15, or zero-extend when req_unsigned is set. A word load passes through unchanged. req_unsigned is ignored for stores and word loads.
- Store merge: wdata[7:0] or wdata[15:0] replaces the addressed lane; all other bytes keep the read value.
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid, resp_err, resp_rdata, ram_we, ram_regce and ram_din are 0; ram_addr is 0.
- Reset mid-operation: the access is abandoned. No ram_we is asserted after the reset edge and no resp_valid is produced for that access.
- Only one access is ever outstanding; req_* is ignored outside IDLE.

## Timing
- Cycle 0 is the accept cycle.
- Error response: resp_valid in cycle 1.
- Word store: write in cycle 1; resp_valid in cycle 2.
- Load: resp_valid in cycle 2+RAM_LATENCY (3 for LOW_LATENCY, 4 for HIGH_PERFORMANCE).
- Sub-word store: read in cycle 1, write in cycle 2+RAM_LATENCY, resp_valid in cycle 3+RAM_LATENCY.
- req_ready returns high the cycle after RESP, so back-to-back accesses are spaced by at least one IDLE cycle.
- All outputs are registered or decoded from state plus latched request. No combinational path exists from req_* to ram_*.

## Structure
- Package dmem_pkg contains:
  - size enum (SZ_B, SZ_H, SZ_W)
  - state enum
  - functions load_extract(word, lane, size, unsigned) and store_merge(old, wdata, lane, size)
- One sub-module, dmem_lane_unit, is natural. It is purely combinational extract/merge built from the package functions and is unit-testable alone.

## Test plan
Setup: DEPTH=1024, BASE=0, RAM word at byte address 0x10 preloaded to 0x8899_AABB.
- Word store 0x10 ← 0xDEAD_BEEF, then word load 0x10 → one ram_we in cycle 1; the load returns 0xDEAD_BEEF with resp_valid in cycle 3.
- Byte store 0x13 ← 0x55 (wdata 0xFFFF_FF55) → single ram_we in cycle 3 with ram_din 0x5599_AABB; resp_valid in cycle 4.
- Loads from 0x8899_AABB:
  - signed byte at 0x11 → 0xFFFF_FFAA
  - unsigned byte at 0x11 → 0x0000_00AA
  - signed half at 0x12 → 0xFFFF_8899
  - unsigned half at 0x12 → 0x0000_8899
- Error cases → resp_valid in cycle 1, resp_err=1, rdata 0, no ram_we:
  - half at 0x11
  - word at 0x12
  - word at 0x1000
  - size 11
- rst pulsed during WAIT of a byte store to 0x10 → no ram_we and no resp_valid follow; the word is still 0x8899_AABB; req_ready=1 the cycle after reset.
- RAM_LATENCY=2 with a RAM model in HIGH_PERFORMANCE mode: word load 0x10 → resp_valid in cycle 4; byte store → ram_we in cycle 4.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StWait,
        StMerge,
        StResp
    } state_e;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    res = {{24{b[7] & ~is_unsigned}}, b};
            SZ_H:    res = {{16{h[15] & ~is_unsigned}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] res;
        res = old;
        case (size)
            SZ_B: res[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (lane[1]) res[31:16] = wdata[15:0];
                else         res[15:0]  = wdata[15:0];
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational load-extract and store-merge for one RAM word.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    assign load_data  = load_extract(rdata_word, lane, size, is_unsigned);
    assign merge_data = store_merge(rdata_word, wdata, lane, size);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word access onto a word-wide RAM with
// read-modify-write for sub-word stores.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_DEPTH   = 1024,
    parameter int unsigned RAM_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int unsigned ADDR_W     = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    output logic              ram_regce,
    input  logic [31:0]       ram_dout
);

    localparam logic [32:0] LIMIT    = 33'(RAM_DEPTH) << 2;
    localparam logic [1:0]  LAST_CNT = 2'(RAM_LATENCY - 1);

    state_e              state_q, state_d;
    logic                we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          lane_q, lane_d, size_q, size_d, cnt_q, cnt_d;
    logic [31:0]         wdata_q, wdata_d, rdata_q, rdata_d, merge_q, merge_d;
    logic [31:0]         offset, load_data, merge_data;
    logic                req_err, word_store;

    assign offset     = req_addr - BASE_ADDR;
    assign word_store = we_q && (size_q == SZ_W);

    always_comb begin
        case (req_size)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = req_addr[0];
            SZ_W:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        // Addresses below BASE_ADDR wrap to a huge offset and fail here too.
        if ({1'b0, offset} >= LIMIT) req_err = 1'b1;
    end

    dmem_lane_unit u_lane (
        .rdata_word  (ram_dout),
        .wdata       (wdata_q),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    err_d   = req_err;
                    addr_d  = offset[ADDR_W+1:2];
                    lane_d  = req_addr[1:0];
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = req_err ? StResp : StAccess;
                end
            end
            StAccess: state_d = word_store ? StResp : StWait;
            StWait: begin
                if (cnt_q == LAST_CNT) begin
                    if (we_q) begin
                        merge_d = merge_data;
                        state_d = StMerge;
                    end else begin
                        rdata_d = load_data;
                        state_d = StResp;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StMerge: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        ram_addr   = '0;
        ram_din    = '0;
        ram_we     = 1'b0;
        ram_regce  = 1'b0;
        case (state_q)
            StIdle: req_ready = 1'b1;
            StAccess: begin
                ram_addr  = addr_q;
                ram_regce = 1'b1;
                if (word_store) begin
                    ram_we  = 1'b1;
                    ram_din = wdata_q;
                end
            end
            StWait: begin
                ram_addr  = addr_q;
                ram_regce = 1'b1;
            end
            StMerge: begin
                ram_addr = addr_q;
                ram_we   = 1'b1;
                ram_din  = merge_q;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance per RAM latency, each with its own RAM model.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, v1, v2, req_we, req_unsigned, sel;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        rdy1, rv1, re1, we1, ce1, rdy2, rv2, re2, we2, ce2;
    logic [31:0] rd1, din1, dout1, rd2, din2, dout2, st2;
    logic [9:0]  ra1, ra2;
    logic [31:0] mem1 [DEPTH];
    logic [31:0] mem2 [DEPTH];
    logic [31:0] ref_mem [2][DEPTH];

    int n_checks, n_err;

    always #5 clk = ~clk;

    dmem_ctrl #(.RAM_DEPTH(DEPTH), .RAM_LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1),
        .ram_addr(ra1), .ram_din(din1), .ram_we(we1), .ram_regce(ce1), .ram_dout(dout1)
    );

    dmem_ctrl #(.RAM_DEPTH(DEPTH), .RAM_LATENCY(2), .BASE_ADDR(BASE)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(rv2), .resp_err(re2), .resp_rdata(rd2),
        .ram_addr(ra2), .ram_din(din2), .ram_we(we2), .ram_regce(ce2), .ram_dout(dout2)
    );

    // Read-first single-port RAMs: latency 1 and latency 2 (output register).
    always @(posedge clk) begin
        dout1 <= mem1[ra1];
        if (we1) mem1[ra1] <= din1;
    end

    always @(posedge clk) begin
        st2 <= mem2[ra2];
        if (ce2) dout2 <= st2;
        if (we2) mem2[ra2] <= din2;
    end

    logic        o_rdy, o_rv, o_err, o_we, o_ce;
    logic [31:0] o_rdata, o_din;
    logic [9:0]  o_ra;
    assign o_rdy   = sel ? rdy2 : rdy1;
    assign o_rv    = sel ? rv2  : rv1;
    assign o_err   = sel ? re2  : re1;
    assign o_we    = sel ? we2  : we1;
    assign o_ce    = sel ? ce2  : ce1;
    assign o_rdata = sel ? rd2  : rd1;
    assign o_din   = sel ? din2 : din1;
    assign o_ra    = sel ? ra2  : ra1;

    // Reference model: byte-addressed view of memory using shifts and masks.
    task automatic model_access(input int s, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                output logic e_err, output logic [31:0] e_rdata, output int e_resp,
                                output int e_nwe, output int e_we_cyc, output logic [31:0] e_din);
        int          lat, nbytes, sh;
        logic [31:0] off, word, mask, v, nw;
        lat      = s + 1;
        off      = addr - BASE;
        nbytes   = 1 << size;
        e_err    = (size == 2'd3) || (off >= 4 * DEPTH) || (addr % nbytes != 0);
        e_rdata  = 0;
        e_nwe    = 0;
        e_we_cyc = 0;
        e_din    = 0;
        if (e_err) begin
            e_resp = 1;
        end else begin
            word = ref_mem[s][off / 4];
            sh   = 8 * int'(addr % 4);
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
            if (!we) begin
                v = (word >> sh) & mask;
                if (nbytes < 4 && !uns && v[8 * nbytes - 1]) v = v | ~mask;
                e_rdata = v;
                e_resp  = 2 + lat;
            end else begin
                nw = (word & ~(mask << sh)) | ((wdata & mask) << sh);
                ref_mem[s][off / 4] = nw;
                e_nwe    = 1;
                e_din    = nw;
                e_we_cyc = (nbytes == 4) ? 1 : 2 + lat;
                e_resp   = (nbytes == 4) ? 2 : 3 + lat;
            end
        end
    endtask

    task automatic do_access(input int s, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                             output int resp_cyc, output logic err, output logic [31:0] rdata,
                             output int nwe, output int we_cyc, output logic [31:0] din);
        sel = (s == 1);
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        if (s == 0) v1 = 1'b1;
        else        v2 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v2 = 1'b0;
        resp_cyc = -1;
        err      = 1'b0;
        rdata    = 0;
        nwe      = 0;
        we_cyc   = 0;
        din      = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (o_we) begin
                nwe++;
                we_cyc = k;
                din    = o_din;
            end
            if (o_rv) begin
                resp_cyc = k;
                err      = o_err;
                rdata    = o_rdata;
                break;
            end
        end
    endtask

    // Keeps the reference model in step for directed accesses.
    task automatic xact(input int s, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        output int resp_cyc, output logic err, output logic [31:0] rdata,
                        output int nwe, output int we_cyc, output logic [31:0] din);
        logic        e_err;
        logic [31:0] e_rdata, e_din;
        int          e_resp, e_nwe, e_we_cyc;
        model_access(s, we, addr, size, uns, wdata, e_err, e_rdata, e_resp, e_nwe, e_we_cyc,
                     e_din);
        do_access(s, we, addr, size, uns, wdata, resp_cyc, err, rdata, nwe, we_cyc, din);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            n_checks++;
            if (o_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL reset_ready dut%0d: got %b expected 1", s, o_rdy);
            end
            n_checks++;
            if ({o_rv, o_err, o_we, o_ce} !== 4'b0) begin
                n_err++;
                $display("FAIL reset_flags dut%0d: got %b expected 0000", s,
                         {o_rv, o_err, o_we, o_ce});
            end
            n_checks++;
            if ({o_rdata, o_din, o_ra} !== 74'b0) begin
                n_err++;
                $display("FAIL reset_data dut%0d: rdata %h din %h addr %h expected 0", s,
                         o_rdata, o_din, o_ra);
            end
        end
    endtask

    task automatic test_init(input int s);
        int          rc, nw, wc;
        logic        e;
        logic [31:0] rd, dn, val;
        for (int i = 0; i < 8; i++) begin
            val = (i == 4) ? 32'h8899_AABB : $urandom;
            xact(s, 1'b1, 32'(i * 4), 2'd2, 1'b0, val, rc, e, rd, nw, wc, dn);
            n_checks++;
            if (rc !== 2 || e !== 1'b0 || dn !== val) begin
                n_err++;
                $display("FAIL init_store dut%0d w%0d: resp %0d din %h expected 2 %h", s, i, rc,
                         dn, val);
            end
        end
    endtask

    task automatic test_word(input int s);
        int          rc, nw, wc;
        logic        e;
        logic [31:0] rd, dn;
        xact(s, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, rc, e, rd, nw, wc, dn);
        n_checks++;
        if (rc !== 2 || nw !== 1 || wc !== 1 || dn !== 32'hDEAD_BEEF || e !== 1'b0) begin
            n_err++;
            $display("FAIL word_store dut%0d: resp %0d nwe %0d wecyc %0d din %h exp 2 1 1 deadbeef",
                     s, rc, nw, wc, dn);
        end
        xact(s, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rc, e, rd, nw, wc, dn);
        n_checks++;
        if (rc !== 3 + s || rd !== 32'hDEAD_BEEF || nw !== 0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL word_load dut%0d: resp %0d rdata %h nwe %0d expected %0d deadbeef 0",
                     s, rc, rd, nw, 3 + s);
        end
    endtask

    task automatic test_byte_store(input int s);
        int          rc, nw, wc;
        logic        e;
        logic [31:0] rd, dn;
        xact(s, 1'b1, 32'h10, 2'd2, 1'b0, 32'h8899_AABB, rc, e, rd, nw, wc, dn);
        xact(s, 1'b1, 32'h13, 2'd0, 1'b0, 32'hFFFF_FF55, rc, e, rd, nw, wc, dn);
        n_checks++;
        if (nw !== 1 || wc !== 3 + s || dn !== 32'h5599_AABB) begin
            n_err++;
            $display("FAIL byte_store_write dut%0d: nwe %0d cyc %0d din %h expected 1 %0d 5599aabb",
                     s, nw, wc, dn, 3 + s);
        end
        n_checks++;
        if (rc !== 4 + s || e !== 1'b0 || rd !== 32'h0) begin
            n_err++;
            $display("FAIL byte_store_resp dut%0d: resp %0d err %b rdata %h expected %0d 0 0",
                     s, rc, e, rd, 4 + s);
        end
    endtask

    task automatic test_loads(input int s);
        int          rc, nw, wc;
        logic        e;
        logic [31:0] rd, dn;
        logic [31:0] la [4];
        logic [1:0]  ls [4];
        logic        lu [4];
        logic [31:0] lx [4];
        la = '{32'h11, 32'h11, 32'h12, 32'h12};
        ls = '{2'd0, 2'd0, 2'd1, 2'd1};
        lu = '{1'b0, 1'b1, 1'b0, 1'b1};
        lx = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899};
        xact(s, 1'b1, 32'h10, 2'd2, 1'b0, 32'h8899_AABB, rc, e, rd, nw, wc, dn);
        for (int i = 0; i < 4; i++) begin
            xact(s, 1'b0, la[i], ls[i], lu[i], 32'hFFFF_FFFF, rc, e, rd, nw, wc, dn);
            n_checks++;
            if (rd !== lx[i] || rc !== 3 + s || nw !== 0 || e !== 1'b0) begin
                n_err++;
                $display("FAIL load%0d dut%0d: rdata %h resp %0d nwe %0d expected %h %0d 0",
                         i, s, rd, rc, nw, lx[i], 3 + s);
            end
        end
    endtask

    task automatic test_errors(input int s);
        int          rc, nw, wc;
        logic        e;
        logic [31:0] rd, dn;
        logic [31:0] ea [4];
        logic [1:0]  es [4];
        logic        ew [4];
        ea = '{32'h11, 32'h12, 32'h1000, 32'h10};
        es = '{2'd1, 2'd2, 2'd2, 2'd3};
        ew = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xact(s, ew[i], ea[i], es[i], 1'b0, 32'h1234_5678, rc, e, rd, nw, wc, dn);
            n_checks++;
            if (rc !== 1 || e !== 1'b1 || rd !== 32'h0 || nw !== 0) begin
                n_err++;
                $display("FAIL error%0d dut%0d: resp %0d err %b rdata %h nwe %0d expected 1 1 0 0",
                         i, s, rc, e, rd, nw);
            end
        end
    endtask

    task automatic test_reset_mid(input int s);
        int          rc, nw, wc, seen;
        logic        e;
        logic [31:0] rd, dn, word;
        xact(s, 1'b1, 32'h10, 2'd2, 1'b0, 32'h8899_AABB, rc, e, rd, nw, wc, dn);
        sel = (s == 1);
        @(negedge clk);
        req_we   = 1'b1;
        req_addr = 32'h10;
        req_size = 2'd0;
        req_wdata = 32'h0000_0077;
        if (s == 0) v1 = 1'b1;
        else        v2 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        @(negedge clk);
        n_checks++;
        if (o_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_ready dut%0d: got %b expected 1", s, o_rdy);
        end
        if (o_we || o_rv) seen++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_we || o_rv) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet dut%0d: got %0d we/resp cycles expected 0", s, seen);
        end
        word = (s == 0) ? mem1[4] : mem2[4];
        n_checks++;
        if (word !== 32'h8899_AABB) begin
            n_err++;
            $display("FAIL reset_mid_ram dut%0d: got %h expected 8899aabb", s, word);
        end
        xact(s, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rc, e, rd, nw, wc, dn);
        n_checks++;
        if (rd !== 32'h8899_AABB || rc !== 3 + s) begin
            n_err++;
            $display("FAIL reset_mid_load dut%0d: rdata %h resp %0d expected 8899aabb %0d", s,
                     rd, rc, 3 + s);
        end
    endtask

    task automatic test_random(input int s);
        int          rc, nw, wc, e_rc, e_nw, e_wc, sz;
        logic        e, ee, we, uns;
        logic [31:0] rd, dn, e_rd, e_dn, addr, wdata;
        logic [1:0]  size;
        for (int i = 0; i < 40; i++) begin
            addr = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
            sz    = $urandom_range(0, 6);
            size  = (sz == 6) ? 2'd3 : 2'(sz % 3);
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            model_access(s, we, addr, size, uns, wdata, ee, e_rd, e_rc, e_nw, e_wc, e_dn);
            do_access(s, we, addr, size, uns, wdata, rc, e, rd, nw, wc, dn);
            n_checks++;
            if (rc !== e_rc || e !== ee) begin
                n_err++;
                $display("FAIL rand_resp dut%0d #%0d: cyc %0d err %b expected %0d %b", s, i, rc, e,
                         e_rc, ee);
            end
            n_checks++;
            if (rd !== e_rd) begin
                n_err++;
                $display("FAIL rand_rdata dut%0d #%0d: got %h expected %h", s, i, rd, e_rd);
            end
            n_checks++;
            if (nw !== e_nw || wc !== e_wc || dn !== e_dn) begin
                n_err++;
                $display("FAIL rand_write dut%0d #%0d: nwe %0d cyc %0d din %h expected %0d %0d %h",
                         s, i, nw, wc, dn, e_nw, e_wc, e_dn);
            end
        end
    endtask

    task automatic test_ram_contents();
        logic [31:0] w;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                w = (s == 0) ? mem1[i] : mem2[i];
                n_checks++;
                if (w !== ref_mem[s][i]) begin
                    n_err++;
                    $display("FAIL ram_word dut%0d w%0d: got %h expected %h", s, i, w,
                             ref_mem[s][i]);
                end
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        sel          = 1'b0;
        rst          = 1'b1;
        v1           = 1'b0;
        v2           = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = '0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            test_init(s);
            test_word(s);
            test_byte_store(s);
            test_loads(s);
            test_errors(s);
            test_reset_mid(s);
            test_random(s);
        end
        test_ram_contents();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
